// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one memory bus between the instruction-fetch port (if_*) and the
// data-access port (mem_*). Data accesses win over fetches. Each granted access
// latches its request fields, drives bus_req from the cycle after the grant,
// and completes on bus_ack with a one-cycle combinational done pulse to the
// owner. There is always one IDLE cycle between accesses.
//
// A flush during an outstanding fetch cannot abort the bus cycle. The arbiter
// moves to IF_DRAIN, keeps bus_req up until the ack arrives, and discards the
// result (no if_done). Data accesses ignore flush.
//
// Optional feature (macro MEM_BUS_ARB_TIMEOUT_EN): a watchdog counts busy
// cycles per access. After TIMEOUT cycles without bus_ack it sets the sticky
// timeout_err, gives the owner a done with rdata=0 (none while draining), and
// returns to IDLE. Without the macro, timeout_err is tied to 0 and the arbiter
// waits for bus_ack indefinitely.
//
// Ports
//   clk, rst                        clock; asynchronous active-low reset
//   if_req, if_addr                 fetch request and its address
//   if_rdata, if_done               fetch result and its completion pulse
//   mem_req/we/sel/addr/wdata       data-access request
//   mem_rdata, mem_done             data-access result and its completion pulse
//   flush                           pipeline flush
//   bus_req/we/sel/addr/wdata       shared-bus request (registered)
//   bus_ack, bus_rdata              shared-bus response
//   stop_from_if, stop_from_mem     stall requests to the stall/flush controller
//   timeout_err                     sticky bus-timeout flag
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [3:0]    mem_sel,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_done,
  input  logic          flush,
  output logic          bus_req,
  output logic          bus_we,
  output logic [3:0]    bus_sel,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic          stop_from_if,
  output logic          stop_from_mem,
  output logic          timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2,
    IF_DRAIN = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_grant_if;
  logic            w_grant_mem;
  logic            w_timeout;

  logic            r_bus_req;
  logic            r_bus_we;
  logic [3:0]      r_bus_sel;
  logic [AW-1:0]   r_bus_addr;
  logic [DW-1:0]   r_bus_wdata;

  // ---------------------------------------------------------------------------
  // Bus watchdog
  // ---------------------------------------------------------------------------
`ifdef MEM_BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_tmo_cnt;
  logic          r_timeout_err;

  // Fires in the TIMEOUT-th busy cycle of an access; an ack in that same
  // cycle still wins and completes the access normally.
  assign w_timeout = (r_state != IDLE) && !bus_ack &&
                     (r_tmo_cnt == CW'(TIMEOUT - 1));

  // The count is cleared in IDLE; every access starts from IDLE, so this
  // restarts it at each grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == IDLE || w_timeout) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + CW'(1);
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  // TIMEOUT only matters when the watchdog is built.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);

  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and completion outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next      = r_state;
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    if_done     = 1'b0;
    if_rdata    = '0;
    mem_done    = 1'b0;
    mem_rdata   = '0;

    case (r_state)
      IDLE: begin
        if (mem_req) begin
          w_next      = MEM_BUSY;
          w_grant_mem = 1'b1;
        end else if (if_req && !flush) begin
          w_next     = IF_BUSY;
          w_grant_if = 1'b1;
        end
      end

      IF_BUSY: begin
        // A flush coinciding with the ack or the timeout discards the fetch.
        if (bus_ack) begin
          w_next   = IDLE;
          if_done  = !flush;
          if_rdata = bus_rdata;
        end else if (w_timeout) begin
          w_next  = IDLE;
          if_done = !flush;
        end else if (flush) begin
          w_next = IF_DRAIN;
        end
      end

      MEM_BUSY: begin
        if (bus_ack) begin
          w_next    = IDLE;
          mem_done  = 1'b1;
          mem_rdata = bus_rdata;
        end else if (w_timeout) begin
          w_next   = IDLE;
          mem_done = 1'b1;
        end
      end

      IF_DRAIN: begin
        // The bus cycle cannot be aborted; wait it out and drop the result.
        if (bus_ack || w_timeout) begin
          w_next = IDLE;
        end
      end

      default: w_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered bus request
  // ---------------------------------------------------------------------------
  // Fields load only on a grant and therefore hold for the whole access.
  // A fetch is a full-word read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else begin
      r_bus_req <= (w_next != IDLE);
      if (w_grant_mem) begin
        r_bus_we    <= mem_we;
        r_bus_sel   <= mem_sel;
        r_bus_addr  <= mem_addr;
        r_bus_wdata <= mem_wdata;
      end else if (w_grant_if) begin
        r_bus_we    <= 1'b0;
        r_bus_sel   <= 4'hF;
        r_bus_addr  <= if_addr;
        r_bus_wdata <= '0;
      end
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_sel   = r_bus_sel;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;

  assign stop_from_if  = if_req  & ~if_done;
  assign stop_from_mem = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed scenarios followed by randomized traffic. Every cycle the outputs
// are compared against a transaction-level reference model: who owns the bus,
// the request it latched, whether a flush has orphaned a fetch, and how long
// the access has been waiting. Build with +define+MEM_BUS_ARB_TIMEOUT_EN to
// exercise the watchdog with TIMEOUT=4.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
  localparam int TMO    = 4;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we, flush, bus_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic        if_done, mem_done, bus_req, bus_we;
  logic [3:0]  bus_sel;
  logic        stop_from_if, stop_from_mem, timeout_err;

  mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_done      (if_done),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_sel      (mem_sel),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_done     (mem_done),
    .flush        (flush),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_sel      (bus_sel),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .stop_from_if (stop_from_if),
    .stop_from_mem(stop_from_mem),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "time limit");
  end

  // ---------------------------------------------------------------------------
  // Check helpers
  // ---------------------------------------------------------------------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef enum int {OWN_NONE, OWN_IF, OWN_MEM} owner_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  owner_e m_owner;
  req_t   m_req;
  bit     m_orphan;   // fetch was flushed; its result must be discarded
  int     m_waited;   // busy cycles already elapsed in this access
  bit     m_err;
  bit     e_if_done, e_mem_done;

  function automatic bit expire_now();
    return TMO_EN && (m_owner != OWN_NONE) && !bus_ack && (m_waited + 1 >= TMO);
  endfunction

  task automatic model_reset();
    m_owner  = OWN_NONE;
    m_req    = '0;
    m_orphan = 1'b0;
    m_waited = 0;
    m_err    = 1'b0;
  endtask

  // Compare all outputs for the current cycle (called at the falling edge).
  task automatic sample();
    bit          busy, fin;
    logic [31:0] rd;
    @(negedge clk);
    busy       = (m_owner != OWN_NONE);
    fin        = busy && (bus_ack || expire_now());
    rd         = bus_ack ? bus_rdata : 32'h0;
    e_if_done  = (m_owner == OWN_IF) && !m_orphan && !flush && fin;
    e_mem_done = (m_owner == OWN_MEM) && fin;

    check1("bus_req", bus_req, busy);
    if (busy) begin
      check32("bus_addr", bus_addr, m_req.addr);
      check1("bus_we", bus_we, m_req.we);
      if (m_owner == OWN_MEM) begin
        check32("bus_sel", {28'h0, bus_sel}, {28'h0, m_req.sel});
        if (m_req.we) check32("bus_wdata", bus_wdata, m_req.wdata);
      end
    end
    check1("if_done", if_done, e_if_done);
    check1("mem_done", mem_done, e_mem_done);
    if (e_if_done)  check32("if_rdata", if_rdata, rd);
    if (e_mem_done) check32("mem_rdata", mem_rdata, rd);
    check1("stop_from_if", stop_from_if, if_req & ~e_if_done);
    check1("stop_from_mem", stop_from_mem, mem_req & ~e_mem_done);
    check1("timeout_err", timeout_err, m_err);
  endtask

  // Advance the model across the rising edge, then step off the edge.
  task automatic advance();
    bit tmo;
    @(posedge clk);
    if (m_owner == OWN_NONE) begin
      if (mem_req) begin
        m_owner  = OWN_MEM;
        m_req    = '{we: mem_we, sel: mem_sel, addr: mem_addr, wdata: mem_wdata};
        m_orphan = 1'b0;
        m_waited = 0;
      end else if (if_req && !flush) begin
        m_owner  = OWN_IF;
        m_req    = '{we: 1'b0, sel: 4'hF, addr: if_addr, wdata: 32'h0};
        m_orphan = 1'b0;
        m_waited = 0;
      end
    end else begin
      tmo = expire_now();
      if (bus_ack || tmo) begin
        if (tmo) m_err = 1'b1;
        m_owner = OWN_NONE;
      end else begin
        if (m_owner == OWN_IF && flush) m_orphan = 1'b1;
        m_waited++;
      end
    end
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    flush = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    model_reset();

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check1("rst_bus_req", bus_req, 1'b0);
    check1("rst_bus_we", bus_we, 1'b0);
    check32("rst_bus_addr", bus_addr, 32'h0);
    check1("rst_timeout_err", timeout_err, 1'b0);
    check1("rst_if_done", if_done, 1'b0);
    rst = 1'b1;
    cycle();

    // Boot fetch, ack two cycles after bus_req rises
    if_req = 1'b1; if_addr = 32'hBFC0_0000;
    cycle();
    cycle();
    cycle();
    bus_ack = 1'b1; bus_rdata = 32'h2408_0001;
    sample();
    check32("boot_bus_addr", bus_addr, 32'hBFC0_0000);
    check1("boot_if_done", if_done, 1'b1);
    check32("boot_if_rdata", if_rdata, 32'h2408_0001);
    check1("boot_stop_if", stop_from_if, 1'b0);
    advance();
    if_req = 1'b0; bus_ack = 1'b0;
    cycle();

    // Simultaneous store and fetch: store first, one IDLE cycle, then fetch
    if_req = 1'b1; if_addr = 32'h8000_0100;
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'hF;
    mem_addr = 32'h8000_2000; mem_wdata = 32'hDEAD_BEEF;
    cycle();
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    sample();
    check1("prio_bus_we", bus_we, 1'b1);
    check32("prio_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    check1("prio_mem_done", mem_done, 1'b1);
    advance();
    mem_req = 1'b0; mem_we = 1'b0; bus_ack = 1'b0;
    sample();
    check1("prio_idle_gap", bus_req, 1'b0);
    advance();
    bus_ack = 1'b1; bus_rdata = 32'h0000_0042;
    sample();
    check1("prio_fetch_we", bus_we, 1'b0);
    check32("prio_fetch_addr", bus_addr, 32'h8000_0100);
    check1("prio_fetch_done", if_done, 1'b1);
    advance();
    if_req = 1'b0; bus_ack = 1'b0;
    cycle();

    // Flush one cycle into a fetch; ack three cycles later is drained
    if_req = 1'b1; if_addr = 32'h8000_0200;
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0; if_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample();
      check1("drain_bus_req", bus_req, 1'b1);
      check1("drain_no_done", if_done, 1'b0);
      advance();
    end
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_0001;
    sample();
    check1("drain_ack_no_done", if_done, 1'b0);
    advance();
    bus_ack = 1'b0;
    sample();
    check1("drain_back_idle", bus_req, 1'b0);
    advance();

    // Flush coinciding with ack during a fetch
    if_req = 1'b1; if_addr = 32'h8000_0300;
    cycle();
    flush = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    sample();
    check1("flush_ack_no_done", if_done, 1'b0);
    advance();
    flush = 1'b0; bus_ack = 1'b0; if_req = 1'b0;
    sample();
    check1("flush_ack_idle", bus_req, 1'b0);
    advance();

    // Flush during a data access is ignored
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'h3; mem_addr = 32'h8000_4000;
    cycle();
    flush = 1'b1;
    cycle();
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    sample();
    check1("mem_flush_done", mem_done, 1'b1);
    check32("mem_flush_rdata", mem_rdata, 32'h0BAD_F00D);
    advance();
    flush = 1'b0; bus_ack = 1'b0; mem_req = 1'b0;
    cycle();

    // Reset in the middle of a data access
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'h1;
    mem_addr = 32'h8000_5000; mem_wdata = 32'h0000_00A5;
    cycle();
    sample();
    rst = 1'b0; bus_ack = 1'b1;
    #1;
    check1("midrst_bus_req", bus_req, 1'b0);
    check1("midrst_no_done", mem_done, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1; bus_ack = 1'b0;
    cycle();
    bus_ack = 1'b1; bus_rdata = 32'h0;
    sample();
    check1("postrst_grant", bus_req, 1'b1);
    check32("postrst_addr", bus_addr, 32'h8000_5000);
    advance();
    mem_req = 1'b0; mem_we = 1'b0; bus_ack = 1'b0;
    cycle();

    // No ack: watchdog expiry, or an indefinite wait without it
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h9000_0000;
    cycle();
`ifdef MEM_BUS_ARB_TIMEOUT_EN
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      bus_rdata = 32'hFFFF_FFFF;
      sample();
      if (mem_done === 1'b1) begin
        lat = i;
        check32("tmo_rdata", mem_rdata, 32'h0);
        advance();
        break;
      end
      advance();
    end
    check32("tmo_latency", lat, 32'd4);
    mem_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check1("tmo_sticky", timeout_err, 1'b1);
      advance();
    end
    rst = 1'b0;
    #1;
    check1("tmo_cleared", timeout_err, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
`else
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (mem_done === 1'b1) lat++;
      advance();
    end
    check32("no_tmo_done_count", lat, 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h7777_0000;
    cycle();
    bus_ack = 1'b0; mem_req = 1'b0;
`endif
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      if (mem_req && e_mem_done) mem_req = 1'b0;
      else if (!mem_req && $urandom_range(3, 0) == 0) begin
        mem_req   = 1'b1;
        mem_we    = 1'($urandom_range(1, 0));
        mem_sel   = 4'($urandom_range(15, 0));
        mem_addr  = $urandom;
        mem_wdata = $urandom;
      end
      if (if_req && (e_if_done || flush)) if_req = 1'b0;
      else if (!if_req && $urandom_range(2, 0) == 0) begin
        if_req  = 1'b1;
        if_addr = $urandom;
      end
      flush     = ($urandom_range(9, 0) == 0);
      bus_rdata = $urandom;
      bus_ack   = (m_owner != OWN_NONE) && ($urandom_range(2, 0) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
